// File: rtl/rgb_stream_capture.sv
// rgb_stream_capture: WS2812-style single-wire receiver.
// Decodes the serial line into bits and stream-reset events, packs 24 bits
// into a pixel word {8'h00, rgb} and queues pixel and marker words in a
// show-ahead FIFO for the downstream RGBW serial output stage.
module rgb_stream_capture #(
  parameter int COUNTER_MAX       = 5000,
  parameter int STREAM_RESET_CLKS = 4800,
  parameter int SAMPLE_TIME_CLKS  = 57,
  parameter int DATA_SIZE         = 32,
  parameter int ADDR_SIZE         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_empty,
  output logic                 wr_full,
  output logic                 overflow
);

  localparam int CW = $clog2(COUNTER_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(COUNTER_MAX);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_TIME_CLKS);
  localparam logic [CW-1:0] CNT_SRST   = CW'(STREAM_RESET_CLKS);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [DATA_SIZE-1:0] MARKER_WORD = DATA_SIZE'(32'h0100_0000);

  // ---------------------------------------------------------------- input sync
  logic sync1_q, sync2_q, prev_q, rise_q;

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sig;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  // ---------------------------------------------------------------- bit decoder
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          bit_stb, srst_stb, bit_val;

  // armed_q marks a pulse still waiting for its sample point, so an idle line
  // after reset (counter passing the sample value) never yields a stray bit.
  assign bit_stb  = armed_q && (cnt_q == CNT_SAMPLE);
  assign srst_stb = (cnt_q == CNT_SRST);
  assign bit_val  = sync2_q;

  // Pulse timer: restart on each edge, count up and saturate at COUNTER_MAX.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (rise_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (bit_stb) armed_d = 1'b0;
    end
  end

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------- word packer
  logic [23:0]          shift_q, shift_d;
  logic [4:0]           nbits_q, nbits_d;
  logic                 wr_en_q, wr_en_d;
  logic [DATA_SIZE-1:0] wr_word_q, wr_word_d;

  // MSB-first shift; emit a pixel on the 24th bit or a marker on stream reset.
  always_comb begin
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    wr_en_d   = 1'b0;
    wr_word_d = wr_word_q;
    if (srst_stb) begin
      shift_d   = '0;
      nbits_d   = '0;
      wr_en_d   = 1'b1;
      wr_word_d = MARKER_WORD;
    end else if (bit_stb) begin
      if (nbits_q == 5'd23) begin
        shift_d   = '0;
        nbits_d   = '0;
        wr_en_d   = 1'b1;
        wr_word_d = DATA_SIZE'({8'h00, shift_q[22:0], bit_val});
      end else begin
        shift_d = {shift_q[22:0], bit_val};
        nbits_d = nbits_q + 5'd1;
      end
    end
  end

  // Packer state register; the FIFO write happens the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      nbits_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_word_q <= '0;
    end else begin
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      wr_en_q   <= wr_en_d;
      wr_word_q <= wr_word_d;
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr_q, rd_ptr_q;
  logic                 empty, full, do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]) &&
                 (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);
  assign do_wr = wr_en_q & ~full;
  assign do_rd = rd_en & ~empty;

  assign rd_data  = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
  assign rd_empty = empty;
  assign wr_full  = full;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= wr_word_q;
  end

  // Pointers and sticky overflow; a write while full is dropped even if a
  // read frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (ADDR_SIZE+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (ADDR_SIZE+1)'(1);
      if (wr_en_q && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_stream_capture.sv
// Bench for rgb_stream_capture: serial stimulus with a word scoreboard.
// The FIFO is instantiated shallow so the fill/overflow case stays short.
module tb_rgb_stream_capture;

  localparam int TB_ADDR  = 3;
  localparam int TB_DEPTH = 1 << TB_ADDR;
  localparam logic [31:0] MARKER = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_empty, wr_full, overflow;

  always #1 clk = ~clk;

  rgb_stream_capture #(
    .COUNTER_MAX      (5000),
    .STREAM_RESET_CLKS(4800),
    .SAMPLE_TIME_CLKS (57),
    .DATA_SIZE        (32),
    .ADDR_SIZE        (TB_ADDR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sig     (sig),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_empty(rd_empty),
    .wr_full (wr_full),
    .overflow(overflow)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;

  typedef struct {
    logic [23:0] rgb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Scoreboard consumer: pop and compare every word the FIFO presents.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rd_empty) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h want none", rd_data);
        end else begin
          check("sb_word", rd_data, exp_q.pop_front());
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sig = 1'b1;
    tick(b ? 62 : 52);
    sig = 1'b0;
    tick(b ? 29 : 67);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[23-i]);
  endtask

  task automatic send_word(input logic [23:0] v, input bit expect_it);
    if (expect_it) exp_q.push_back({8'h00, v});
    send_bits(v, 24);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !rd_empty) && n < 300) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [23:0] pat(input int i);
    return 24'h102030 + 24'(i) * 24'h010101;
  endfunction

  initial begin
    vecs[0] = '{24'hA5C3F0, 32'h00A5_C3F0};
    vecs[1] = '{24'h000000, 32'h0000_0000};
    vecs[2] = '{24'hFFFFFF, 32'h00FF_FFFF};
    vecs[3] = '{24'h123456, 32'h0012_3456};
    vecs[4] = '{24'h800001, 32'h0080_0001};

    // Reset state, then idle line: one marker at exactly 4800 clocks.
    do_reset();
    check1("rst_empty", rd_empty, 1'b1);
    check1("rst_full", wr_full, 1'b0);
    check1("rst_ovf", overflow, 1'b0);
    tick(4795);
    check1("idle_before_4800", rd_empty, 1'b1);
    tick(10);
    check1("idle_after_4800", rd_empty, 1'b0);
    check("idle_marker_head", rd_data, MARKER);
    exp_q.push_back(MARKER);
    mon_en = 1'b1;
    wait_drain("idle_marker_drain");
    tick(10000);
    check1("idle_no_extra", rd_empty, 1'b1);

    // Table of pixel words sent back-to-back.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp);
      send_bits(vecs[i].rgb, 24);
    end
    wait_drain("table_drain");

    // Partial frame, stream reset, then a full word.
    do_reset();
    send_bits(24'hB6D000, 10);
    exp_q.push_back(MARKER);
    tick(4900);
    send_word(24'h123456, 1'b1);
    wait_drain("partial_drain");

    // Aborted pulse: second edge 30 clocks after the first.
    do_reset();
    sig = 1'b1;
    tick(10);
    sig = 1'b0;
    tick(20);
    send_word(24'hC0FFEE, 1'b1);
    wait_drain("abort_drain");

    // Fill to full, drop one, then drain in order.
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < TB_DEPTH; i++) send_word(pat(i), 1'b0);
    tick(5);
    check1("fill_full", wr_full, 1'b1);
    check1("fill_no_ovf", overflow, 1'b0);
    send_word(pat(TB_DEPTH), 1'b0);
    tick(5);
    check1("drop_full", wr_full, 1'b1);
    check1("drop_ovf", overflow, 1'b1);
    for (int i = 0; i < TB_DEPTH; i++) exp_q.push_back({8'h00, pat(i)});
    mon_en = 1'b1;
    wait_drain("fill_drain");
    tick(2);
    check1("drain_empty", rd_empty, 1'b1);
    check1("drain_not_full", wr_full, 1'b0);
    check1("ovf_sticky", overflow, 1'b1);

    // Reset mid-frame after 12 bits, with a word left in the FIFO.
    mon_en = 1'b0;
    send_word(24'hABCDEF, 1'b0);
    tick(5);
    check1("pre_rst_nonempty", rd_empty, 1'b0);
    send_bits(24'hFFF000, 12);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check1("midrst_empty", rd_empty, 1'b1);
    check1("midrst_ovf", overflow, 1'b0);
    check1("midrst_full", wr_full, 1'b0);
    mon_en = 1'b1;
    send_word(24'h3C5A96, 1'b1);
    wait_drain("midrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
